uart_cmd_responder: RTL

Host-side command endpoint at the far end of the Uart byte streams. It consumes received bytes from the Uart receive FIFO and parses a binary register-access protocol. It drives a simple register bus and returns one response byte per command into the Uart transmit FIFO. It sits between the Uart block and the local control/status registers.

---
 rtl/uart_cmd_pkg.sv | 32 +++
 rtl/uart_cmd_timeout.sv | 30 +++
 rtl/uart_cmd_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command responder.
// Holds the protocol byte values and the responder FSM state type.
package uart_cmd_pkg;

    // Command opcodes received from the host
    localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'

    // Response bytes returned to the host
    localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K' write done
    localparam logic [7:0] RSP_BAD = 8'h3F;  // '?' unknown opcode or address out of range
    localparam logic [7:0] RSP_ERR = 8'h21;  // '!' framing error on a received byte

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        EXEC,
        SEND
    } cmd_state_t;

    // States in which the responder is willing to take a received byte
    function automatic logic is_rx_state(input cmd_state_t s);
        return (s == IDLE) || (s == GET_ADDR) || (s == GET_DATA);
    endfunction

    // States that wait for the remainder of a partially received command
    function automatic logic is_get_state(input cmd_state_t s);
        return (s == GET_ADDR) || (s == GET_DATA);
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter for the UART command responder.
// Counts clocks while enabled, saturates at LIMIT and flags expiry.
// Only built when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_timeout #(
    parameter logic [23:0] LIMIT = 24'd5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count_reg;

    // Idle-clock counter: cleared on request, saturating so expiry stays asserted
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LIMIT_CNT)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign expired = enable && (count_reg == LIMIT_CNT);

endmodule

// File: rtl/uart_cmd_responder.sv
// Binary register-access command endpoint behind a UART byte stream.
// Parses 'W' addr data / 'R' addr commands, drives a simple register bus
// and returns exactly one response byte per command.
// Optional build macro: UART_CMD_TIMEOUT_EN adds an inter-byte timeout that
// silently drops a command whose bytes stop arriving.
module uart_cmd_responder #(
    parameter int          ADDR_W      = 4,
    parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        from_uart_data_i,
    input  logic              from_uart_valid_i,
    input  logic              from_uart_error_i,
    output logic              from_uart_ready_o,
    output logic [7:0]        to_uart_data_o,
    output logic              to_uart_valid_o,
    output logic              to_uart_error_o,
    input  logic              to_uart_ready_i,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [7:0]        reg_wdata_o,
    output logic              reg_wr_o,
    output logic              reg_rd_o,
    input  logic [7:0]        reg_rdata_i,
    output logic              busy_o
);

    import uart_cmd_pkg::*;

    cmd_state_t state_reg, state_next;
    logic       is_wr_reg, is_wr_next;
    logic [7:0] addr_reg,  addr_next;
    logic [7:0] wdata_reg, wdata_next;
    logic [7:0] rsp_reg,   rsp_next;

    logic byte_take;
    logic in_get;
    logic addr_ok;
    logic timeout_expired;

    // The full address byte is kept so out-of-range addresses can be rejected
    assign addr_ok   = ((addr_reg >> ADDR_W) == 8'd0);
    assign in_get    = is_get_state(state_reg);
    assign byte_take = from_uart_valid_i && from_uart_ready_o;

`ifdef UART_CMD_TIMEOUT_EN
    // Counter runs only while waiting for more bytes; any taken byte or any
    // other state keeps it at zero, so entry to GET_* always starts from 0.
    uart_cmd_timeout #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_get || byte_take),
        .enable  (in_get),
        .expired (timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            is_wr_reg <= 1'b0;
            addr_reg  <= 8'd0;
            wdata_reg <= 8'd0;
            rsp_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            is_wr_reg <= is_wr_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rsp_reg   <= rsp_next;
        end
    end

    // Next-state, datapath loads and register-bus strobes
    always_comb begin
        state_next = state_reg;
        is_wr_next = is_wr_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rsp_next   = rsp_reg;
        reg_wr_o   = 1'b0;
        reg_rd_o   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (byte_take) begin
                    if (from_uart_error_i) begin
                        rsp_next   = RSP_ERR;
                        state_next = SEND;
                    end else if (from_uart_data_i == CMD_WR) begin
                        is_wr_next = 1'b1;
                        state_next = GET_ADDR;
                    end else if (from_uart_data_i == CMD_RD) begin
                        is_wr_next = 1'b0;
                        state_next = GET_ADDR;
                    end else begin
                        rsp_next   = RSP_BAD;
                        state_next = SEND;
                    end
                end
            end

            GET_ADDR: begin
                if (byte_take) begin
                    if (from_uart_error_i) begin
                        rsp_next   = RSP_ERR;
                        state_next = SEND;
                    end else begin
                        addr_next  = from_uart_data_i;
                        state_next = is_wr_reg ? GET_DATA : EXEC;
                    end
                end else if (timeout_expired) begin
                    state_next = IDLE;
                end
            end

            GET_DATA: begin
                if (byte_take) begin
                    if (from_uart_error_i) begin
                        rsp_next   = RSP_ERR;
                        state_next = SEND;
                    end else begin
                        wdata_next = from_uart_data_i;
                        state_next = EXEC;
                    end
                end else if (timeout_expired) begin
                    state_next = IDLE;
                end
            end

            EXEC: begin
                // Read data is sampled here: reg_addr_o has been stable since GET_ADDR
                if (!addr_ok) begin
                    rsp_next = RSP_BAD;
                end else if (is_wr_reg) begin
                    reg_wr_o = 1'b1;
                    rsp_next = RSP_OK;
                end else begin
                    reg_rd_o = 1'b1;
                    rsp_next = reg_rdata_i;
                end
                state_next = SEND;
            end

            SEND: begin
                if (to_uart_ready_i) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Ready and valid derive from the registered state, so both are glitch-free
    // and the response byte register is never reloaded while SEND holds it.
    assign from_uart_ready_o = is_rx_state(state_reg);
    assign to_uart_valid_o   = (state_reg == SEND);
    assign to_uart_data_o    = rsp_reg;
    assign to_uart_error_o   = 1'b0;
    assign reg_addr_o        = addr_reg[ADDR_W-1:0];
    assign reg_wdata_o       = wdata_reg;
    assign busy_o            = (state_reg != IDLE);

endmodule
